// File: rtl/enc_pkg.sv
// Shared encoder constants and the binder-scheduler state encoding.
// Pure declarations; no logic, no latency, no flow control.
package enc_pkg;

    localparam int HV_DIM          = 1024;
    localparam int FEATURES_PER_CC = 8;
    localparam int SHIFTS          = FEATURES_PER_CC;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        BIND  = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4,
        DONE  = 3'd5
    } enc_sched_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/enc_binder_scheduler.sv
// Walks one sample through all binder packs: fetch -> bind -> wait BINDER_LAT -> hand-off, >= 2+BINDER_LAT cycles/chunk.
// Fetch stalls on lvl_valid, hand-off holds bind_valid/bind_idx stable until bind_ready; all outputs Moore.
module enc_binder_scheduler
    import enc_pkg::*;
#(
    parameter int  NUM_FEATURES    = 96,
    parameter int  FEATURES_PER_CC = enc_pkg::FEATURES_PER_CC,
    parameter int  BINDER_LAT      = 1,
    localparam int NUM_PACKS       = NUM_FEATURES / FEATURES_PER_CC,
    localparam int IDX_W           = idx_width(NUM_PACKS)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic                 lvl_req,
    output logic [IDX_W-1:0]     lvl_addr,
    input  logic                 lvl_valid,
    output logic                 start_encoding,
    output logic [NUM_PACKS-1:0] pack_en,
    output logic                 bind_valid,
    input  logic                 bind_ready,
    output logic [IDX_W-1:0]     bind_idx,
    output logic                 bind_last,
    output logic                 done,
    output logic                 busy
);

    localparam int                   WAIT_W    = $clog2(BINDER_LAT + 1);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_PACKS - 1);
    localparam logic [WAIT_W-1:0]    WAIT_INIT = (BINDER_LAT >= 2) ? WAIT_W'(BINDER_LAT - 2) : '0;
    localparam logic [NUM_PACKS-1:0] PACK_ONE  = NUM_PACKS'(1);

    if ((NUM_FEATURES % FEATURES_PER_CC) != 0 || BINDER_LAT < 1) begin : g_bad_cfg
        $error("enc_binder_scheduler: NUM_FEATURES must be a multiple of FEATURES_PER_CC and BINDER_LAT >= 1");
    end

    enc_sched_state_t  state_q, state_d;
    logic [IDX_W-1:0]  chunk_q, chunk_d;
    logic [WAIT_W-1:0] wait_q,  wait_d;

    always_ff @(posedge clk) begin
        if (nrst) begin
            state_q <= IDLE;
            chunk_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            chunk_q <= chunk_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        chunk_d = chunk_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    state_d = FETCH;
                    chunk_d = '0;
                end
            end
            FETCH: begin
                if (lvl_valid) begin
                    state_d = BIND;
                end
            end
            BIND: begin
                // WAIT covers the remaining BINDER_LAT-1 cycles so OUT lands exactly BINDER_LAT after BIND.
                if (BINDER_LAT == 1) begin
                    state_d = OUT;
                end else begin
                    wait_d  = WAIT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (wait_q == '0) begin
                    state_d = OUT;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            OUT: begin
                if (bind_ready) begin
                    if (chunk_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        chunk_d = chunk_q + IDX_W'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                chunk_d = '0;
                wait_d  = '0;
            end
        endcase
    end

    always_comb begin
        sample_ready   = 1'b0;
        lvl_req        = 1'b0;
        lvl_addr       = '0;
        start_encoding = 1'b0;
        pack_en        = '0;
        bind_valid     = 1'b0;
        bind_idx       = '0;
        bind_last      = 1'b0;
        done           = 1'b0;
        busy           = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                sample_ready = 1'b1;
            end
            FETCH: begin
                lvl_req  = 1'b1;
                lvl_addr = chunk_q;
            end
            BIND: begin
                start_encoding = 1'b1;
                pack_en        = PACK_ONE << chunk_q;
            end
            OUT: begin
                bind_valid = 1'b1;
                bind_idx   = chunk_q;
                bind_last  = (chunk_q == LAST_IDX);
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = (state_q != IDLE);
            end
        endcase
    end

endmodule

// File: tb/tb_enc_binder_scheduler.sv
// Bench for enc_binder_scheduler: instance 0 with BINDER_LAT=1, instance 1 with BINDER_LAT=3.
module tb_enc_binder_scheduler;

    localparam int NP = 12;

    localparam int M_ZERO  = 0;
    localparam int M_TIED  = 1;
    localparam int M_STALL = 2;
    localparam int M_RAND  = 3;
    localparam int M_DELAY = 4;

    logic clk;
    logic rst [2];
    logic sv  [2];
    logic lv  [2];
    logic br  [2];

    logic          sample_ready   [2];
    logic          lvl_req        [2];
    logic [3:0]    lvl_addr       [2];
    logic          start_encoding [2];
    logic [NP-1:0] pack_en        [2];
    logic          bind_valid     [2];
    logic [3:0]    bind_idx       [2];
    logic          bind_last      [2];
    logic          done           [2];
    logic          busy           [2];

    enc_binder_scheduler #(.NUM_FEATURES(96), .FEATURES_PER_CC(8), .BINDER_LAT(1)) dut0 (
        .clk(clk), .nrst(rst[0]), .sample_valid(sv[0]), .sample_ready(sample_ready[0]),
        .lvl_req(lvl_req[0]), .lvl_addr(lvl_addr[0]), .lvl_valid(lv[0]),
        .start_encoding(start_encoding[0]), .pack_en(pack_en[0]), .bind_valid(bind_valid[0]),
        .bind_ready(br[0]), .bind_idx(bind_idx[0]), .bind_last(bind_last[0]),
        .done(done[0]), .busy(busy[0])
    );

    enc_binder_scheduler #(.NUM_FEATURES(96), .FEATURES_PER_CC(8), .BINDER_LAT(3)) dut1 (
        .clk(clk), .nrst(rst[1]), .sample_valid(sv[1]), .sample_ready(sample_ready[1]),
        .lvl_req(lvl_req[1]), .lvl_addr(lvl_addr[1]), .lvl_valid(lv[1]),
        .start_encoding(start_encoding[1]), .pack_en(pack_en[1]), .bind_valid(bind_valid[1]),
        .bind_ready(br[1]), .bind_idx(bind_idx[1]), .bind_last(bind_last[1]),
        .done(done[1]), .busy(busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d act=%0h exp=%0h cyc=%0d", nm, k, act, exp, cyc);
        end
    endtask

    // Reference model: a per-sample timeline walked chunk by chunk.
    logic          e_sready [2];
    logic          e_req    [2];
    logic [3:0]    e_addr   [2];
    logic          e_se     [2];
    logic [NP-1:0] e_pen    [2];
    logic          e_bv     [2];
    logic [3:0]    e_bidx   [2];
    logic          e_blast  [2];
    logic          e_done   [2];
    logic          e_busy   [2];

    task automatic set_blank(input int k);
        e_sready[k] = 1'b0; e_req[k] = 1'b0; e_addr[k] = '0; e_se[k] = 1'b0; e_pen[k] = '0;
        e_bv[k] = 1'b0; e_bidx[k] = '0; e_blast[k] = 1'b0; e_done[k] = 1'b0; e_busy[k] = 1'b1;
    endtask

    task automatic set_idle(input int k);
        set_blank(k);
        e_sready[k] = 1'b1;
        e_busy[k]   = 1'b0;
    endtask

    task automatic model_run(input int k, input int lat);
        bit ab;
        bit fin;
        logic [NP-1:0] one;
        one = 1;
        set_idle(k);
        forever begin
            @(posedge clk);
            if (rst[k] || !sv[k]) begin
                set_idle(k);
                continue;
            end
            ab = 1'b0;
            for (int c = 0; c < NP; c++) begin
                set_blank(k); e_req[k] = 1'b1; e_addr[k] = 4'(c);
                fin = 1'b0;
                while (!fin) begin
                    @(posedge clk);
                    if (rst[k]) begin ab = 1'b1; fin = 1'b1; end
                    else if (lv[k]) fin = 1'b1;
                end
                if (ab) break;
                set_blank(k); e_se[k] = 1'b1; e_pen[k] = one << c;
                @(posedge clk);
                if (rst[k]) begin ab = 1'b1; break; end
                for (int w = 1; w < lat && !ab; w++) begin
                    set_blank(k);
                    @(posedge clk);
                    if (rst[k]) ab = 1'b1;
                end
                if (ab) break;
                set_blank(k); e_bv[k] = 1'b1; e_bidx[k] = 4'(c); e_blast[k] = (c == NP - 1);
                fin = 1'b0;
                while (!fin) begin
                    @(posedge clk);
                    if (rst[k]) begin ab = 1'b1; fin = 1'b1; end
                    else if (br[k]) fin = 1'b1;
                end
                if (ab) break;
            end
            if (!ab) begin
                set_blank(k); e_done[k] = 1'b1;
                @(posedge clk);
            end
            set_idle(k);
        end
    endtask

    initial model_run(0, 1);
    initial model_run(1, 3);

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                for (int k = 0; k < 2; k++) begin
                    chk("sample_ready",   k, 32'(sample_ready[k]),   32'(e_sready[k]));
                    chk("lvl_req",        k, 32'(lvl_req[k]),        32'(e_req[k]));
                    chk("start_encoding", k, 32'(start_encoding[k]), 32'(e_se[k]));
                    chk("pack_en",        k, 32'(pack_en[k]),        32'(e_pen[k]));
                    chk("bind_valid",     k, 32'(bind_valid[k]),     32'(e_bv[k]));
                    chk("bind_last",      k, 32'(bind_last[k]),      32'(e_blast[k]));
                    chk("done",           k, 32'(done[k]),           32'(e_done[k]));
                    chk("busy",           k, 32'(busy[k]),           32'(e_busy[k]));
                    if (e_req[k]) chk("lvl_addr", k, 32'(lvl_addr[k]), 32'(e_addr[k]));
                    if (e_bv[k])  chk("bind_idx", k, 32'(bind_idx[k]), 32'(e_bidx[k]));
                end
            end
        end
    end

    // Event monitor feeding the hand-computed expectations.
    int            se_cnt   [2] = '{0, 0};
    int            done_cnt [2] = '{0, 0};
    logic [NP-1:0] pen_q0 [$];
    int            lat_q1 [$];
    int            se_cyc1   = 0;
    logic          bv_prev1  = 1'b0;
    int            blast_cnt0 = 0;
    int            blast_idx0 = 0;
    int            bv3_cnt0   = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (start_encoding[0] === 1'b1) begin
                se_cnt[0]++;
                pen_q0.push_back(pack_en[0]);
            end
            if (start_encoding[1] === 1'b1) begin
                se_cnt[1]++;
                se_cyc1 = cyc;
            end
            if (bind_valid[1] === 1'b1 && !bv_prev1) lat_q1.push_back(cyc - se_cyc1);
            bv_prev1 = (bind_valid[1] === 1'b1);
            if (bind_valid[0] === 1'b1 && bind_last[0] === 1'b1) begin
                blast_cnt0++;
                blast_idx0 = int'(bind_idx[0]);
            end
            if (bind_valid[0] === 1'b1 && bind_idx[0] === 4'd3) bv3_cnt0++;
            for (int k = 0; k < 2; k++) if (done[k] === 1'b1) done_cnt[k]++;
        end
    end

    // lvl_valid / bind_ready driver, one behaviour per instance selected by mode.
    int mode      [2] = '{M_ZERO, M_ZERO};
    int stall_cnt [2] = '{0, 0};
    int rc        [2] = '{0, 0};

    initial begin
        lv[0] = 1'b0; lv[1] = 1'b0; br[0] = 1'b0; br[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                case (mode[k])
                    M_TIED: begin lv[k] = 1'b1; br[k] = 1'b1; end
                    M_STALL: begin
                        lv[k] = 1'b1;
                        if (bind_valid[k] === 1'b1 && bind_idx[k] === 4'd3 && stall_cnt[k] < 5) begin
                            br[k] = 1'b0;
                            stall_cnt[k]++;
                        end else begin
                            br[k] = 1'b1;
                        end
                    end
                    M_RAND: begin
                        lv[k] = 1'($urandom_range(0, 1));
                        br[k] = 1'($urandom_range(0, 1));
                    end
                    M_DELAY: begin
                        br[k] = 1'b1;
                        if (lvl_req[k] === 1'b1) rc[k]++;
                        else rc[k] = 0;
                        lv[k] = (rc[k] >= 3);
                    end
                    default: begin lv[k] = 1'b0; br[k] = 1'b0; end
                endcase
                if (mode[k] != M_STALL) stall_cnt[k] = 0;
            end
        end
    end

    task automatic start_sample(input int k, output int acc);
        @(negedge clk);
        sv[k] = 1'b1;
        acc = cyc;
        @(negedge clk);
        sv[k] = 1'b0;
    endtask

    task automatic run_to_done(input int k, input int budget, output int dcyc, output bit ok);
        ok = 1'b0;
        dcyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done[k] === 1'b1) begin
                dcyc = cyc;
                sv[k] = 1'b0;
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  acc, dcyc, base, base_d, qb;
        bit  ok;
        logic [NP-1:0] one;
        one = 1;
        rst[0] = 1'b1; rst[1] = 1'b1; sv[0] = 1'b0; sv[1] = 1'b0;

        // 1: reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_sample_ready", k, 32'(sample_ready[k]),   32'd1);
            chk("rst_busy",         k, 32'(busy[k]),           32'd0);
            chk("rst_start_enc",    k, 32'(start_encoding[k]), 32'd0);
            chk("rst_pack_en",      k, 32'(pack_en[k]),        32'd0);
            chk("rst_done",         k, 32'(done[k]),           32'd0);
            chk("rst_lvl_req",      k, 32'(lvl_req[k]),        32'd0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;
        cmp_en = 1'b1;
        mode[0] = M_TIED;
        repeat (2) @(negedge clk);

        // 2: defaults, all tied ready
        qb = pen_q0.size();
        base = blast_cnt0;
        start_sample(0, acc);
        run_to_done(0, 200, dcyc, ok);
        chk("t2_timeout", 0, 32'(ok), 32'd1);
        chk("t2_done_latency", 0, 32'(dcyc - acc), 32'd37);
        repeat (3) @(negedge clk);
        chk("t2_pulse_count", 0, 32'(pen_q0.size() - qb), 32'd12);
        for (int i = 0; i < NP; i++)
            if (qb + i < pen_q0.size()) chk("t2_pack_en_seq", 0, 32'(pen_q0[qb + i]), 32'(one << i));
        chk("t2_last_count", 0, 32'(blast_cnt0 - base), 32'd1);
        chk("t2_last_idx", 0, 32'(blast_idx0), 32'd11);

        // 3: five-cycle bundler stall on chunk 3
        mode[0] = M_STALL;
        base = bv3_cnt0;
        start_sample(0, acc);
        run_to_done(0, 300, dcyc, ok);
        chk("t3_timeout", 0, 32'(ok), 32'd1);
        chk("t3_done_latency", 0, 32'(dcyc - acc), 32'd42);
        chk("t3_stalls", 0, 32'(stall_cnt[0]), 32'd5);
        mode[0] = M_TIED;
        repeat (3) @(negedge clk);
        chk("t3_chunk3_hold", 0, 32'(bv3_cnt0 - base), 32'd6);

        // 4: BINDER_LAT=3 with two-cycle level fetch delay
        mode[1] = M_DELAY;
        qb = lat_q1.size();
        base = se_cnt[1];
        start_sample(1, acc);
        run_to_done(1, 400, dcyc, ok);
        chk("t4_timeout", 1, 32'(ok), 32'd1);
        chk("t4_done_latency", 1, 32'(dcyc - acc), 32'd85);
        repeat (3) @(negedge clk);
        chk("t4_pulse_count", 1, 32'(se_cnt[1] - base), 32'd12);
        chk("t4_lat_samples", 1, 32'(lat_q1.size() - qb), 32'd12);
        for (int i = qb; i < lat_q1.size(); i++) chk("t4_bind_lat", 1, 32'(lat_q1[i]), 32'd3);

        // 5: reset while waiting on chunk 7
        mode[1] = M_TIED;
        repeat (2) @(negedge clk);
        base_d = done_cnt[1];
        start_sample(1, acc);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (start_encoding[1] === 1'b1 && pack_en[1] === 12'h080) begin ok = 1'b1; break; end
        end
        chk("t5_reach_chunk7", 1, 32'(ok), 32'd1);
        @(negedge clk);
        chk("t5_wait_busy", 1, 32'(busy[1]), 32'd1);
        chk("t5_wait_quiet", 1, 32'(bind_valid[1]), 32'd0);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        chk("t5_post_rst_ready", 1, 32'(sample_ready[1]), 32'd1);
        chk("t5_post_rst_busy",  1, 32'(busy[1]),         32'd0);
        chk("t5_post_rst_done",  1, 32'(done[1]),         32'd0);
        repeat (3) @(negedge clk);
        chk("t5_no_done", 1, 32'(done_cnt[1] - base_d), 32'd0);
        start_sample(1, acc);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (start_encoding[1] === 1'b1) begin ok = 1'b1; break; end
        end
        chk("t5_restart_seen", 1, 32'(ok), 32'd1);
        chk("t5_restart_chunk0", 1, 32'(pack_en[1]), 32'h001);
        run_to_done(1, 400, dcyc, ok);
        chk("t5_timeout", 1, 32'(ok), 32'd1);
        repeat (3) @(negedge clk);
        chk("t5_one_done", 1, 32'(done_cnt[1] - base_d), 32'd1);

        // 6: spurious inputs while busy
        mode[0] = M_RAND;
        base = se_cnt[0];
        base_d = done_cnt[0];
        @(negedge clk);
        sv[0] = 1'b1;
        run_to_done(0, 3000, dcyc, ok);
        chk("t6_timeout", 0, 32'(ok), 32'd1);
        mode[0] = M_TIED;
        repeat (3) @(negedge clk);
        chk("t6_pulse_count", 0, 32'(se_cnt[0] - base), 32'd12);
        chk("t6_done_count", 0, 32'(done_cnt[0] - base_d), 32'd1);
        chk("t6_idle_after", 0, 32'(sample_ready[0]), 32'd1);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
